// File: rtl/median_pkg.sv
// Shared constants and types for the 3x3 median window generator.
// Holds the default geometry, the window index map and the pixel type.
package median_pkg;

    localparam int DATA_SIZE_DEF  = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    // Window indices in raster order: top row, middle row, bottom row.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    localparam int WIN_SIZE = 9;

    typedef logic [DATA_SIZE_DEF-1:0] pix_t;

endpackage

// File: rtl/median_window_gen_if.sv
// Pixel-in / window-out bundle between the pixel source, the window
// generator and the downstream median sorter. DATA_SIZE must match the
// generator's DATA_SIZE.
interface median_window_gen_if #(
    parameter int DATA_SIZE = median_pkg::DATA_SIZE_DEF
);

    logic                 pixValid;
    logic [DATA_SIZE-1:0] pixIn;
    logic                 sof;

    logic [DATA_SIZE-1:0] dataOut0;
    logic [DATA_SIZE-1:0] dataOut1;
    logic [DATA_SIZE-1:0] dataOut2;
    logic [DATA_SIZE-1:0] dataOut3;
    logic [DATA_SIZE-1:0] dataOut4;
    logic [DATA_SIZE-1:0] dataOut5;
    logic [DATA_SIZE-1:0] dataOut6;
    logic [DATA_SIZE-1:0] dataOut7;
    logic [DATA_SIZE-1:0] dataOut8;
    logic                 winValid;
    logic                 frameDone;

    // Pixel source: drives the stream, observes the windows.
    modport master (
        output pixValid, pixIn, sof,
        input  dataOut0, dataOut1, dataOut2, dataOut3, dataOut4,
               dataOut5, dataOut6, dataOut7, dataOut8, winValid, frameDone
    );

    // Window generator: consumes the stream, produces the windows.
    modport slave (
        input  pixValid, pixIn, sof,
        output dataOut0, dataOut1, dataOut2, dataOut3, dataOut4,
               dataOut5, dataOut6, dataOut7, dataOut8, winValid, frameDone
    );

endinterface

// File: rtl/median_line_buf.sv
// Single line delay: DEPTH-entry RAM with combinational read and
// synchronous write at the same address, so a read returns the value
// stored one line earlier (read-before-write).
module median_line_buf #(
    parameter int DEPTH = median_pkg::IMG_WIDTH_DEF,
    parameter int WIDTH = median_pkg::DATA_SIZE_DEF
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Store the incoming pixel over the one just read out.
    // NOTE: the array has no reset branch so it can map onto RAM; stale
    // contents are masked by the window-valid logic in the parent.
    // NOTE: non-blocking so every register in the design samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator feeding the median sorter.
// Tracks raster position, delays two lines through cascaded line buffers
// and shifts a 3x3 window register on every accepted pixel.
// Optional macro MEDIAN_OUT_REG_EN adds one extra output register stage
// on dataOut0..8, winValid and frameDone (latency +1 cycle).
module median_window_gen
    import median_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    median_window_gen_if.slave  bus
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

    logic [COL_W-1:0]     col_q, col_d, cur_col;
    logic [ROW_W-1:0]     row_q, row_d, cur_row;
    logic [DATA_SIZE-1:0] win_q [WIN_SIZE];
    logic [DATA_SIZE-1:0] win_d [WIN_SIZE];
    logic                 win_valid_q, win_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic [DATA_SIZE-1:0] line_a_out;   // same column, previous row
    logic [DATA_SIZE-1:0] line_b_out;   // same column, two rows up

    logic [DATA_SIZE-1:0] out_win [WIN_SIZE];
    logic                 out_valid;
    logic                 out_done;

    median_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_SIZE)
    ) u_line_a (
        .clk     (clk),
        .we_i    (bus.pixValid),
        .addr_i  (cur_col),
        .wdata_i (bus.pixIn),
        .rdata_o (line_a_out)
    );

    median_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_SIZE)
    ) u_line_b (
        .clk     (clk),
        .we_i    (bus.pixValid),
        .addr_i  (cur_col),
        .wdata_i (line_a_out),
        .rdata_o (line_b_out)
    );

    // Position of the incoming pixel, next counters, window shift and strobes.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cur_col      = bus.sof ? '0 : col_q;
        cur_row      = bus.sof ? '0 : row_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (bus.pixValid) begin
            win_valid_d  = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
            frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end

            win_d[WIN_TL] = win_q[WIN_TC];
            win_d[WIN_TC] = win_q[WIN_TR];
            win_d[WIN_TR] = line_b_out;
            win_d[WIN_ML] = win_q[WIN_MC];
            win_d[WIN_MC] = win_q[WIN_MR];
            win_d[WIN_MR] = line_a_out;
            win_d[WIN_BL] = win_q[WIN_BC];
            win_d[WIN_BC] = win_q[WIN_BR];
            win_d[WIN_BR] = bus.pixIn;
        end
    end

    // Position counters, window register and strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef MEDIAN_OUT_REG_EN
    logic [DATA_SIZE-1:0] out_win_q [WIN_SIZE];
    logic                 out_valid_q;
    logic                 out_done_q;

    // Free-running retiming stage; strobes stay one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_win_q   <= '{default: '0};
            out_valid_q <= 1'b0;
            out_done_q  <= 1'b0;
        end else begin
            out_win_q   <= win_q;
            out_valid_q <= win_valid_q;
            out_done_q  <= frame_done_q;
        end
    end

    assign out_win   = out_win_q;
    assign out_valid = out_valid_q;
    assign out_done  = out_done_q;
`else
    assign out_win   = win_q;
    assign out_valid = win_valid_q;
    assign out_done  = frame_done_q;
`endif

    assign bus.dataOut0  = out_win[WIN_TL];
    assign bus.dataOut1  = out_win[WIN_TC];
    assign bus.dataOut2  = out_win[WIN_TR];
    assign bus.dataOut3  = out_win[WIN_ML];
    assign bus.dataOut4  = out_win[WIN_MC];
    assign bus.dataOut5  = out_win[WIN_MR];
    assign bus.dataOut6  = out_win[WIN_BL];
    assign bus.dataOut7  = out_win[WIN_BC];
    assign bus.dataOut8  = out_win[WIN_BR];
    assign bus.winValid  = out_valid;
    assign bus.frameDone = out_done;

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen on a 4x4 image with pixel
// value 4*row+col. Expected windows are queued as pixels are issued and
// popped by an independent monitor whenever winValid is seen.
module tb_median_window_gen;
    import median_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DS = 8;
`ifdef MEDIAN_OUT_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [71:0] win;
        logic        fd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [71:0] exp_win [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_window_gen_if #(.DATA_SIZE(DS)) bus ();

    median_window_gen #(
        .DATA_SIZE  (DS),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [71:0] outs();
        return {bus.dataOut0, bus.dataOut1, bus.dataOut2,
                bus.dataOut3, bus.dataOut4, bus.dataOut5,
                bus.dataOut6, bus.dataOut7, bus.dataOut8};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every window strobe.
    exp_t e_mon;
    always @(negedge clk) begin
        if (bus.winValid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_window: got window %0h at cycle %0d, expected none", outs(), cyc);
            end else begin
                e_mon = sb.pop_front();
                check("win_data", outs(), e_mon.win);
                check("win_frameDone", 72'(bus.frameDone), 72'(e_mon.fd));
                check("win_cycle", 72'(cyc), 72'(e_mon.cyc));
            end
        end else if (bus.frameDone !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_frameDone: got %b at cycle %0d, expected 0", bus.frameDone, cyc);
        end
    end

    // Issue one pixel; queue the window it should complete.
    task automatic send(input logic [7:0] v, input logic s, input int r, input int c);
        exp_t e;
        @(negedge clk);
        bus.pixValid = 1'b1;
        bus.pixIn    = v;
        bus.sof      = s;
        if (r >= 2 && c >= 2) begin
            e.win = exp_win[(r - 2) * 2 + (c - 2)];
            e.fd  = (r == H - 1) && (c == W - 1);
            e.cyc = cyc + 1 + EXTRA;
            sb.push_back(e);
        end
    endtask

    // Idle cycles; outputs must hold and winValid stay low across them.
    task automatic idle(input int n);
        logic [71:0] snap;
        snap = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i >= 1 + EXTRA) begin
                check("gap_hold", outs(), snap);
                check("gap_winValid", 72'(bus.winValid), 72'(0));
            end
            snap         = outs();
            bus.pixValid = 1'b0;
            bus.sof      = 1'b0;
            bus.pixIn    = 8'hEE;
        end
    endtask

    task automatic frame(input logic with_sof, input logic gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(8'(4 * r + c), with_sof && r == 0 && c == 0, r, c);
                if (gaps) idle(1 + (4 * r + c) % 3);
            end
        end
    endtask

    task automatic drain();
        idle(1);
        repeat (3) @(negedge clk);
        check("sb_empty", 72'(sb.size()), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_win[0] = {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10};
        exp_win[1] = {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11};
        exp_win[2] = {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14};
        exp_win[3] = {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

        bus.pixValid = 1'b0;
        bus.pixIn    = '0;
        bus.sof      = 1'b0;
        rst          = 1'b0;
        #1;
        check("rst_dataOut", outs(), 72'(0));
        check("rst_winValid", 72'(bus.winValid), 72'(0));
        check("rst_frameDone", 72'(bus.frameDone), 72'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Continuous pass-through frame.
        frame(1'b1, 1'b0);
        drain();

        // Same frame with 1..3 idle cycles after every pixel.
        frame(1'b1, 1'b1);
        drain();

        // Abort frame 1 with a sof at (1,2); only the new frame yields windows.
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 0, i / 4, i % 4);
        frame(1'b1, 1'b0);
        drain();

        // Back-to-back frames, the second without sof.
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        drain();

        // Asynchronous reset mid-frame, then a frame without sof.
        for (int i = 0; i < 11; i++) send(8'(i), i == 0, i / 4, i % 4);
        idle(3);
        check("pre_rst_window", outs(), exp_win[0]);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_dataOut", outs(), 72'(0));
        check("midrst_winValid", 72'(bus.winValid), 72'(0));
        check("midrst_frameDone", 72'(bus.frameDone), 72'(0));
        @(negedge clk);
        rst = 1'b1;
        frame(1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
